// File: rtl/morse_pkg.sv
// Shared types and default timing ratios for the Morse keyer.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_ELEM_GAP,
        ST_CHAR_GAP,
        ST_WORD_GAP
    } state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int unsigned DEF_DOT_CYCLES = 50;
    localparam int unsigned DEF_MAX_SYM    = 8;
    localparam int unsigned DEF_DASH_UNITS = 3;
    localparam int unsigned DEF_CHAR_UNITS = 3;
    localparam int unsigned DEF_WORD_UNITS = 7;

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running unit prescaler; tick marks the last cycle of each Morse unit.
module morse_unit_timer #(
    parameter int unsigned DOT_CYCLES = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DOT_CYCLES > 1) ? $clog2(DOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DOT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Clearing on acceptance makes unit boundaries phase-exact to the transfer.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one coded character per handshake and keys it with ITU timing.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int unsigned DOT_CYCLES = DEF_DOT_CYCLES,
    parameter int unsigned MAX_SYM    = DEF_MAX_SYM,
    parameter int unsigned LEN_W      = $clog2(MAX_SYM + 1) + 1,
    parameter int unsigned DASH_UNITS = DEF_DASH_UNITS,
    parameter int unsigned CHAR_UNITS = DEF_CHAR_UNITS,
    parameter int unsigned WORD_UNITS = DEF_WORD_UNITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_SYM-1:0] in_sym,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               in_space,
    output logic               key_out,
    output logic               busy,
    output logic               err
);

    localparam int unsigned UNIT_W = $clog2(DASH_UNITS + WORD_UNITS + 1);

    state_t             state;
    logic [MAX_SYM-1:0] sym_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [UNIT_W-1:0]  units;

    logic tick;
    logic accept_c;
    logic bad_len_c;
    logic last_elem_c;
    logic unit_done_c;

    assign accept_c    = in_valid && in_ready;
    assign bad_len_c   = (in_len > LEN_W'(MAX_SYM));
    assign last_elem_c = ((idx + LEN_W'(1)) == len_q);
    assign unit_done_c = tick && (units == UNIT_W'(1));

    function automatic logic [UNIT_W-1:0] elem_units(input logic s);
        return (s == SYM_DASH) ? UNIT_W'(DASH_UNITS) : UNIT_W'(1);
    endfunction

    morse_unit_timer #(
        .DOT_CYCLES(DOT_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (accept_c),
        .tick(tick)
    );

    // Sequencer; the current element is always sym_q[0], shifted out after each mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sym_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            units    <= '0;
            key_out  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            err <= 1'b0;
            if (state != ST_IDLE && tick && !unit_done_c) begin
                units <= units - UNIT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (in_space) begin
                            state    <= ST_WORD_GAP;
                            units    <= UNIT_W'(WORD_UNITS - CHAR_UNITS);
                            busy     <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (bad_len_c) begin
                            err <= 1'b1;
                        end else if (in_len == '0) begin
                            state    <= ST_CHAR_GAP;
                            units    <= UNIT_W'(CHAR_UNITS);
                            busy     <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= ST_MARK;
                            sym_q    <= in_sym;
                            len_q    <= in_len;
                            idx      <= '0;
                            units    <= elem_units(in_sym[0]);
                            key_out  <= 1'b1;
                            busy     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_MARK: begin
                    if (unit_done_c) begin
                        key_out <= 1'b0;
                        if (last_elem_c) begin
                            state <= ST_CHAR_GAP;
                            units <= UNIT_W'(CHAR_UNITS);
                        end else begin
                            state <= ST_ELEM_GAP;
                            units <= UNIT_W'(1);
                            sym_q <= sym_q >> 1;
                        end
                    end
                end
                ST_ELEM_GAP: begin
                    if (unit_done_c) begin
                        state   <= ST_MARK;
                        idx     <= idx + LEN_W'(1);
                        units   <= elem_units(sym_q[0]);
                        key_out <= 1'b1;
                    end
                end
                ST_CHAR_GAP, ST_WORD_GAP: begin
                    if (unit_done_c) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    key_out  <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: key patterns per busy window checked against hand-built runs.
module tb_morse_keyer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sym;
    logic [4:0] in_len;
    logic       in_space;
    logic       key_out;
    logic       busy;
    logic       err;

    typedef struct {
        logic [255:0] pat;
        int           len;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] ep;
    int           el;
    logic [255:0] cap;
    int           cap_len;
    logic         prev_busy;
    logic         aborted;
    int           err_seen;
    int           cyc;
    int           checks;
    int           errors;
    int           t_e;
    int           t_t;
    int           t_x;

    morse_keyer #(
        .DOT_CYCLES(4),
        .MAX_SYM   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sym  (in_sym),
        .in_len  (in_len),
        .in_space(in_space),
        .key_out (key_out),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s act=%0d exp=%0d", nm, act, expv);
        end
    endtask

    task automatic exp_begin();
        ep = '0;
        el = 0;
    endtask

    task automatic exp_run(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            ep[el] = v;
            el = el + 1;
        end
    endtask

    task automatic exp_push();
        exp_t e;
        e.pat = ep;
        e.len = el;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] s, input logic [4:0] l, input logic sp, output int acc);
        bit ok;
        in_sym   = s;
        in_len   = l;
        in_space = sp;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL send_timeout in_ready stuck low len=%0d", l);
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL idle_timeout busy never dropped");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: captures key_out over each busy window and scores it on busy fall.
    always @(negedge clk) begin
        if (rst) begin
            if (busy) aborted = 1'b1;
            cap     = '0;
            cap_len = 0;
        end else begin
            checks = checks + 1;
            if (in_ready === busy) begin
                errors = errors + 1;
                $display("FAIL ready_vs_busy in_ready=%0b busy=%0b cyc=%0d", in_ready, busy, cyc);
            end
            if (busy) begin
                if (cap_len < 256) cap[cap_len] = key_out;
                cap_len = cap_len + 1;
            end else if (prev_busy) begin
                if (aborted) begin
                    aborted = 1'b0;
                end else begin
                    checks = checks + 1;
                    if (exp_q.size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL key_window unexpected busy window len=%0d", cap_len);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (cap_len != e.len || cap != e.pat) begin
                            errors = errors + 1;
                            $display("FAIL key_window len act=%0d exp=%0d pat act=%h exp=%h",
                                     cap_len, e.len, cap, e.pat);
                        end
                    end
                end
                cap     = '0;
                cap_len = 0;
            end else if (key_out) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL idle_key key_out high while idle cyc=%0d", cyc);
            end
            if (err) err_seen = err_seen + 1;
        end
        prev_busy = busy;
    end

    initial begin
        checks    = 0;
        errors    = 0;
        err_seen  = 0;
        cyc       = 0;
        cap       = '0;
        cap_len   = 0;
        prev_busy = 1'b0;
        aborted   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sym    = '0;
        in_len    = '0;
        in_space  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_key", key_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 'A': dot, dash
        exp_begin(); exp_run(1, 4); exp_run(0, 4); exp_run(1, 12); exp_run(0, 12); exp_push();
        send(8'b10, 5'd2, 1'b0, t_x);
        chk("a_busy_n1", busy, 1);
        chk("a_key_n1", key_out, 1);
        wait_idle();

        // 'E' then 'T' back to back
        exp_begin(); exp_run(1, 4); exp_run(0, 12); exp_push();
        exp_begin(); exp_run(1, 12); exp_run(0, 12); exp_push();
        send(8'b0, 5'd1, 1'b0, t_e);
        send(8'b1, 5'd1, 1'b0, t_t);
        chk("et_accept_spacing", t_t - t_e, 17);
        wait_idle();

        // 'E' then word space
        exp_begin(); exp_run(1, 4); exp_run(0, 12); exp_push();
        exp_begin(); exp_run(0, 16); exp_push();
        send(8'b0, 5'd1, 1'b0, t_x);
        send(8'hFF, 5'd9, 1'b1, t_x);
        chk("space_busy", busy, 1);
        chk("space_key", key_out, 0);
        chk("space_err", err, 0);
        wait_idle();

        // Illegal lengths
        send(8'b0, 5'd9, 1'b0, t_x);
        chk("len9_err", err, 1);
        chk("len9_key", key_out, 0);
        chk("len9_busy", busy, 0);
        chk("len9_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("len9_err_drop", err, 0);
        repeat (2) @(posedge clk);
        #1;
        send(8'b0, 5'd31, 1'b0, t_x);
        chk("len31_err", err, 1);
        wait_idle();

        // Eight dots: longest legal character
        exp_begin();
        for (int i = 0; i < 7; i++) begin
            exp_run(1, 4);
            exp_run(0, 4);
        end
        exp_run(1, 4); exp_run(0, 12); exp_push();
        send(8'h00, 5'd8, 1'b0, t_x);
        wait_idle();

        // Empty character
        exp_begin(); exp_run(0, 12); exp_push();
        send(8'hFF, 5'd0, 1'b0, t_x);
        chk("len0_busy", busy, 1);
        chk("len0_key", key_out, 0);
        wait_idle();

        // Reset mid-dash of 'O', then a clean 'E'
        send(8'b111, 5'd3, 1'b0, t_x);
        repeat (6) @(posedge clk);
        #1;
        chk("o_mid_key", key_out, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("o_rst_key", key_out, 0);
        chk("o_rst_busy", busy, 0);
        chk("o_rst_ready", in_ready, 1);
        rst = 1'b0;
        exp_begin(); exp_run(1, 4); exp_run(0, 12); exp_push();
        send(8'b0, 5'd1, 1'b0, t_x);
        wait_idle();

        // Reset and valid together: no transfer
        in_sym   = 8'b1;
        in_len   = 5'd1;
        in_space = 1'b0;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rstv_busy", busy, 0);
        chk("rstv_key", key_out, 0);
        @(posedge clk);
        #1;
        chk("rstv_busy2", busy, 0);
        repeat (4) @(posedge clk);
        #1;

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("err_pulse_count", err_seen, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
